// File: rtl/vector_mem_pkg.sv
// Shared types and default sizing for the vector memory sequencer.
package vector_mem_pkg;

  localparam int LANES         = 8;
  localparam int DATA_WIDTH    = 32;
  localparam int ADDRESS_WIDTH = 32;
  localparam int MEM_SIZE      = 4096;
  localparam int LEN_WIDTH     = $clog2(LANES + 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  typedef logic [LANES-1:0][DATA_WIDTH-1:0] lane_vec_t;

endpackage

// File: rtl/vector_addr_gen.sv
// Lane address walker: strided address register, lane index, range check
// and last-lane detect for one vector request.
module vector_addr_gen #(
  parameter int LANES         = vector_mem_pkg::LANES,
  parameter int ADDRESS_WIDTH = vector_mem_pkg::ADDRESS_WIDTH,
  parameter int MEM_SIZE      = vector_mem_pkg::MEM_SIZE,
  parameter int LEN_WIDTH     = $clog2(LANES + 1),
  parameter int IDX_WIDTH     = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     step,
  input  logic [ADDRESS_WIDTH-1:0] base,
  input  logic [ADDRESS_WIDTH-1:0] stride,
  input  logic [LEN_WIDTH-1:0]     len,
  output logic [ADDRESS_WIDTH-1:0] addr,
  output logic [IDX_WIDTH-1:0]     idx,
  output logic                     out_of_range,
  output logic                     last
);

  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [ADDRESS_WIDTH-1:0] stride_q;
  logic [IDX_WIDTH-1:0]     idx_q;
  logic [LEN_WIDTH-1:0]     len_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      stride_q <= '0;
      idx_q    <= '0;
      len_q    <= '0;
    end else if (start) begin
      addr_q   <= base;
      stride_q <= stride;
      idx_q    <= '0;
      len_q    <= len;
    end else if (step) begin
      // Two's complement stride: plain modular add gives negative strides and wrap.
      addr_q <= addr_q + stride_q;
      idx_q  <= idx_q + IDX_WIDTH'(1);
    end
  end

  assign addr         = addr_q;
  assign idx          = idx_q;
  assign out_of_range = (addr_q >= ADDRESS_WIDTH'(MEM_SIZE));
  assign last         = (LEN_WIDTH'(idx_q) == (len_q - LEN_WIDTH'(1)));

endmodule

// File: rtl/vector_mem_sequencer.sv
// Splits one strided vector load/store into per-lane memory accesses and
// assembles the load result and error status for the MEM stage.
//
// state  | meaning
// IDLE   | ready for a request; latches it on req_valid
// ACCESS | one lane per cycle at the walked address
// DONE   | one-cycle response pulse, then back to IDLE
module vector_mem_sequencer #(
  parameter int LANES         = vector_mem_pkg::LANES,
  parameter int DATA_WIDTH    = vector_mem_pkg::DATA_WIDTH,
  parameter int ADDRESS_WIDTH = vector_mem_pkg::ADDRESS_WIDTH,
  parameter int MEM_SIZE      = vector_mem_pkg::MEM_SIZE,
  parameter int LEN_WIDTH     = $clog2(LANES + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [ADDRESS_WIDTH-1:0]    req_base,
  input  logic [ADDRESS_WIDTH-1:0]    req_stride,
  input  logic [LEN_WIDTH-1:0]        req_len,
  input  logic [LANES*DATA_WIDTH-1:0] req_wdata,
  output logic                        resp_valid,
  output logic                        resp_error,
  output logic [LANES*DATA_WIDTH-1:0] resp_rdata,
  output logic [ADDRESS_WIDTH-1:0]    mem_readAddress,
  output logic [ADDRESS_WIDTH-1:0]    mem_writeAddress,
  output logic                        mem_writeEnable,
  output logic [DATA_WIDTH-1:0]       mem_inputData,
  input  logic [DATA_WIDTH-1:0]       mem_outputData
);

  import vector_mem_pkg::*;

  localparam int IDX_WIDTH = (LANES > 1) ? $clog2(LANES) : 1;

  state_t                           state;
  logic                             write_q;
  logic                             err_q;
  logic [LANES-1:0][DATA_WIDTH-1:0] wdata_q;
  logic [LANES-1:0][DATA_WIDTH-1:0] rbuf_q;

  logic                     accept;
  logic                     step;
  logic [LEN_WIDTH-1:0]     len_clamped;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [IDX_WIDTH-1:0]     idx;
  logic                     oor;
  logic                     last;

  assign accept      = (state == IDLE) && req_valid;
  assign step        = (state == ACCESS);
  assign len_clamped = (req_len > LEN_WIDTH'(LANES)) ? LEN_WIDTH'(LANES) : req_len;

  vector_addr_gen #(
    .LANES         (LANES),
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .MEM_SIZE      (MEM_SIZE),
    .LEN_WIDTH     (LEN_WIDTH),
    .IDX_WIDTH     (IDX_WIDTH)
  ) u_addr_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (accept),
    .step         (step),
    .base         (req_base),
    .stride       (req_stride),
    .len          (len_clamped),
    .addr         (addr),
    .idx          (idx),
    .out_of_range (oor),
    .last         (last)
  );

  // Decoded from registered state, so the async reset kills the strobe at once.
  assign mem_readAddress  = addr;
  assign mem_writeAddress = addr;
  assign mem_writeEnable  = step && write_q && !oor;
  assign mem_inputData    = (step && write_q) ? wdata_q[idx] : '0;
  assign resp_rdata       = rbuf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      wdata_q    <= '0;
      rbuf_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            write_q    <= req_write;
            wdata_q    <= req_wdata;
            rbuf_q     <= '0;
            err_q      <= 1'b0;
            resp_error <= 1'b0;
            req_ready  <= 1'b0;
            if (len_clamped == '0) begin
              state      <= DONE;
              resp_valid <= 1'b1;
            end else begin
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!write_q) rbuf_q[idx] <= oor ? '0 : mem_outputData;
          if (oor) err_q <= 1'b1;
          if (last) begin
            state      <= DONE;
            resp_valid <= 1'b1;
            resp_error <= err_q | oor;
          end
        end
        DONE: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Directed bench for vector_mem_sequencer with a behavioural memory model.
module tb_vector_mem_sequencer;
  import vector_mem_pkg::*;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [31:0]   req_base;
  logic [31:0]   req_stride;
  logic [3:0]    req_len;
  logic [255:0]  req_wdata;
  logic          resp_valid;
  logic          resp_error;
  logic [255:0]  resp_rdata;
  logic [31:0]   mem_readAddress;
  logic [31:0]   mem_writeAddress;
  logic          mem_writeEnable;
  logic [31:0]   mem_inputData;
  logic [31:0]   mem_outputData;

  vector_mem_sequencer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_base         (req_base),
    .req_stride       (req_stride),
    .req_len          (req_len),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_error       (resp_error),
    .resp_rdata       (resp_rdata),
    .mem_readAddress  (mem_readAddress),
    .mem_writeAddress (mem_writeAddress),
    .mem_writeEnable  (mem_writeEnable),
    .mem_inputData    (mem_inputData),
    .mem_outputData   (mem_outputData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:4095];
  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];
  int          wr_edge [$];
  int          edge_cnt = 0;
  int          rv_cnt = 0;
  int          acc_edge = 0;
  int          wr_base = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  always_comb
    mem_outputData = (mem_readAddress < 32'd4096) ? mem[mem_readAddress[11:0]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (mem_writeEnable) begin
      if (mem_writeAddress < 32'd4096) mem[mem_writeAddress[11:0]] = mem_inputData;
      wr_addr.push_back(mem_writeAddress);
      wr_data.push_back(mem_inputData);
      wr_edge.push_back(edge_cnt + 1);
    end
  end

  always @(posedge clk) edge_cnt <= edge_cnt + 1;
  always @(negedge clk) if (resp_valid) rv_cnt <= rv_cnt + 1;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_req(input logic w, input logic [31:0] base, input logic [31:0] stride,
                         input logic [3:0] len, input lane_vec_t wd,
                         output int rcyc, output lane_vec_t rdata, output logic rerr);
    @(negedge clk);
    wr_base    = wr_addr.size();
    req_valid  = 1'b1;
    req_write  = w;
    req_base   = base;
    req_stride = stride;
    req_len    = len;
    req_wdata  = wd;
    @(posedge clk); #1;
    acc_edge  = edge_cnt;
    req_valid = 1'b0;
    rcyc  = -1;
    rdata = '0;
    rerr  = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (resp_valid) begin
        rcyc  = k;
        rdata = resp_rdata;
        rerr  = resp_error;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    chk("resp_pulse_one_cycle", resp_valid, 1'b0);
    chk("ready_back_in_idle", req_ready, 1'b1);
  endtask

  lane_vec_t exp_v;
  lane_vec_t wd;
  lane_vec_t rd;
  logic      rerr;
  int        rcyc;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_base = '0; req_stride = '0; req_len = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_error", resp_error, 1'b0);
    chk("rst_resp_rdata", resp_rdata, '0);
    chk("rst_we", mem_writeEnable, 1'b0);
    chk("rst_raddr", mem_readAddress, '0);
    chk("rst_waddr", mem_writeAddress, '0);
    chk("rst_wdata", mem_inputData, '0);
    rst_n = 1'b1;

    // 8-lane unit-stride load
    for (int i = 0; i < 8; i++) mem[16+i] = 32'hA000_00A0 + i;
    exp_v = '0;
    for (int i = 0; i < 8; i++) exp_v[i] = 32'hA000_00A0 + i;
    run_req(1'b0, 32'd16, 32'd1, 4'd8, '0, rcyc, rd, rerr);
    chk("ld8_latency", rcyc, 9);
    chk("ld8_rdata", rd, exp_v);
    chk("ld8_error", rerr, 1'b0);
    chk("ld8_no_writes", wr_addr.size() - wr_base, 0);
    chk("ld8_rdata_held", resp_rdata, exp_v);

    // strided store, upper lanes carry data that must never land
    mem[101] = 32'h0000_1234;
    wd = '0;
    wd[0] = 32'd11; wd[1] = 32'd22; wd[2] = 32'd33; wd[3] = 32'd44;
    for (int i = 4; i < 8; i++) wd[i] = 32'h5555_0000 + i;
    run_req(1'b1, 32'd100, 32'd3, 4'd4, wd, rcyc, rd, rerr);
    chk("st4_latency", rcyc, 5);
    chk("st4_error", rerr, 1'b0);
    chk("st4_write_count", wr_addr.size() - wr_base, 4);
    for (int j = 0; j < 4; j++) begin
      if (wr_base + j < wr_addr.size()) begin
        chk($sformatf("st4_addr%0d", j), wr_addr[wr_base+j], 32'd100 + 3*j);
        chk($sformatf("st4_data%0d", j), wr_data[wr_base+j], 32'd11 * (j + 1));
        chk($sformatf("st4_cycle%0d", j), wr_edge[wr_base+j] - acc_edge, j + 1);
      end
    end
    chk("st4_mem101", mem[101], 32'h0000_1234);
    chk("st4_mem109", mem[109], 32'd44);
    chk("st4_rdata", rd, '0);

    // load running off the top of memory
    mem[4094] = 32'h0000_00B0;
    mem[4095] = 32'h0000_00B1;
    exp_v = '0;
    exp_v[0] = 32'h0000_00B0;
    exp_v[1] = 32'h0000_00B1;
    run_req(1'b0, 32'd4094, 32'd1, 4'd3, '0, rcyc, rd, rerr);
    chk("oor_latency", rcyc, 4);
    chk("oor_rdata", rd, exp_v);
    chk("oor_error", rerr, 1'b1);

    // negative stride wrapping to address 0
    wd = '0;
    wd[0] = 32'hC0DE_0005; wd[1] = 32'hC0DE_0000;
    run_req(1'b1, 32'd5, 32'hFFFF_FFFB, 4'd2, wd, rcyc, rd, rerr);
    chk("neg_error", rerr, 1'b0);
    chk("neg_write_count", wr_addr.size() - wr_base, 2);
    if (wr_base + 1 < wr_addr.size()) begin
      chk("neg_addr0", wr_addr[wr_base], 32'd5);
      chk("neg_addr1", wr_addr[wr_base+1], 32'd0);
    end
    chk("neg_mem5", mem[5], 32'hC0DE_0005);
    chk("neg_mem0", mem[0], 32'hC0DE_0000);

    // zero-length store
    wd = '1;
    run_req(1'b1, 32'd50, 32'd1, 4'd0, wd, rcyc, rd, rerr);
    chk("len0_latency", rcyc, 1);
    chk("len0_no_writes", wr_addr.size() - wr_base, 0);
    chk("len0_rdata", rd, '0);
    chk("len0_error", rerr, 1'b0);

    // stride 0 store: last lane wins
    wd = '0;
    wd[0] = 32'd7; wd[1] = 32'd8; wd[2] = 32'd9;
    run_req(1'b1, 32'd200, 32'd0, 4'd3, wd, rcyc, rd, rerr);
    chk("s0_write_count", wr_addr.size() - wr_base, 3);
    chk("s0_mem200", mem[200], 32'd9);

    // oversize length is clamped to 8 lanes
    exp_v = '0;
    for (int i = 0; i < 8; i++) exp_v[i] = 32'hA000_00A0 + i;
    run_req(1'b0, 32'd16, 32'd1, 4'd15, '0, rcyc, rd, rerr);
    chk("clamp_latency", rcyc, 9);
    chk("clamp_rdata", rd, exp_v);

    // reset while lane 2 of an 8-lane store is in flight
    wd = '0;
    for (int i = 0; i < 8; i++) wd[i] = 32'h0000_0300 + i;
    @(negedge clk);
    wr_base    = wr_addr.size();
    req_valid  = 1'b1; req_write = 1'b1;
    req_base   = 32'd300; req_stride = 32'd1; req_len = 4'd8; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_mid_we_before", mem_writeEnable, 1'b1);
    rv_cnt = 0;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_we_dropped", mem_writeEnable, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("rst_mid_write_count", wr_addr.size() - wr_base, 2);
    chk("rst_mid_mem300", mem[300], 32'h0000_0300);
    chk("rst_mid_mem301", mem[301], 32'h0000_0301);
    chk("rst_mid_mem302", mem[302], 32'h0);
    chk("rst_mid_ready", req_ready, 1'b1);
    chk("rst_mid_no_resp", rv_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
